ide_pio_bus: RTL and testbench

- Low-level ATA/IDE PIO bus cycle engine, instantiated as `ide` inside the single-block disk controller.
- Converts one-word register read/write requests into timed chip-select, address, DIOR-/DIOW- strobe sequences on the IDE cable.
- Returns a one-cycle completion pulse plus held read data.

---
 rtl/ide_pkg.sv | 36 +++
 rtl/ide_pio_bus.sv | 142 ++++++++++++++
 tb/tb_ide_pio_bus.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/ide_pkg.sv
// Shared ATA/IDE definitions: register addresses, status bits, command codes and the PIO bus state.
package ide_pkg;

  // {cs1_n, cs0_n, DA[2:0]}
  localparam logic [4:0] REG_DATA    = 5'b10000;
  localparam logic [4:0] REG_ERROR   = 5'b10001;  // read ERROR, write FEATURE
  localparam logic [4:0] REG_SECCNT  = 5'b10010;
  localparam logic [4:0] REG_SECNUM  = 5'b10011;
  localparam logic [4:0] REG_CYLLOW  = 5'b10100;
  localparam logic [4:0] REG_CYLHIGH = 5'b10101;
  localparam logic [4:0] REG_DRVHEAD = 5'b10110;
  localparam logic [4:0] REG_STATUS  = 5'b10111;  // read STATUS, write COMMAND
  localparam logic [4:0] REG_ALTER   = 5'b01110;  // read ALT STATUS, write DEVCTRL

  localparam int ST_BSY  = 7;
  localparam int ST_DRDY = 6;
  localparam int ST_DRQ  = 3;
  localparam int ST_ERR  = 0;

  localparam logic [7:0] CMD_READ  = 8'h20;
  localparam logic [7:0] CMD_WRITE = 8'h30;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_DONE
  } bus_state_t;

  // States in which chip select and address are driven onto the cable
  function automatic logic bus_active(bus_state_t s);
    return (s == S_SETUP) || (s == S_STROBE) || (s == S_HOLD);
  endfunction

endpackage

// File: rtl/ide_pio_bus.sv
// ATA PIO register cycle engine: setup / strobe / hold timing on CS, DA, DIOR-, DIOW-; IDE_DATA_OE_EN adds a write-data enable.
// Latency 1+SETUP+PULSE+HOLD+1 clocks from request to done; no backpressure, a request is accepted only in IDLE.
module ide_pio_bus
  import ide_pkg::*;
#(
  parameter int SETUP_CYC = 4,
  parameter int PULSE_CYC = 15,
  parameter int HOLD_CYC  = 2,
  parameter int CNT_W     = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ata_rd,
  input  logic        ata_wr,
  input  logic [4:0]  ata_addr,
  input  logic [15:0] ata_in,
  output logic [15:0] ata_out,
  output logic        ata_done,
  input  logic [15:0] ide_data_in,
  output logic [15:0] ide_data_out,
  output logic        ide_dior,
  output logic        ide_diow,
  output logic [1:0]  ide_cs,
  output logic [2:0]  ide_da
`ifdef IDE_DATA_OE_EN
  ,
  output logic        ide_data_oe
`endif
);

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);

  bus_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [4:0]       addr_q, addr_nxt;
  logic [15:0]      wdat_q, wdat_nxt;
  logic             rd_q, rd_nxt;
  logic             capture;
  logic             nxt_act;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    addr_nxt  = addr_q;
    wdat_nxt  = wdat_q;
    rd_nxt    = rd_q;
    capture   = 1'b0;
    case (state)
      S_IDLE: begin
        if (ata_rd || ata_wr) begin
          state_nxt = S_SETUP;
          cnt_nxt   = SETUP_LD;
          addr_nxt  = ata_addr;
          wdat_nxt  = ata_in;
          rd_nxt    = ata_rd;  // read wins when both are requested
        end
      end
      S_SETUP: begin
        if (cnt == '0) begin
          state_nxt = S_STROBE;
          cnt_nxt   = PULSE_LD;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_STROBE: begin
        if (cnt == '0) begin
          state_nxt = S_HOLD;
          cnt_nxt   = HOLD_LD;
          capture   = rd_q;  // sample on the edge that raises DIOR-
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt == '0) begin
          state_nxt = S_DONE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign nxt_act = bus_active(state_nxt);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      addr_q <= '0;
      wdat_q <= '0;
      rd_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      addr_q <= addr_nxt;
      wdat_q <= wdat_nxt;
      rd_q   <= rd_nxt;
    end
  end

  // Cable outputs are registered from the next state so they change together with it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ide_dior     <= 1'b1;
      ide_diow     <= 1'b1;
      ide_cs       <= 2'b11;
      ide_da       <= 3'b000;
      ide_data_out <= 16'h0000;
      ata_out      <= 16'h0000;
      ata_done     <= 1'b0;
    end else begin
      ide_dior <= !((state_nxt == S_STROBE) && rd_nxt);
      ide_diow <= !((state_nxt == S_STROBE) && !rd_nxt);
      ide_cs   <= nxt_act ? addr_nxt[4:3] : 2'b11;
      ide_da   <= nxt_act ? addr_nxt[2:0] : 3'b000;
      ata_done <= (state_nxt == S_DONE);
      if ((state == S_IDLE) && (state_nxt == S_SETUP) && !rd_nxt) begin
        ide_data_out <= wdat_nxt;
      end
      if (capture) begin
        ata_out <= ide_data_in;
      end
    end
  end

`ifdef IDE_DATA_OE_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ide_data_oe <= 1'b0;
    end else begin
      ide_data_oe <= nxt_act && !rd_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_ide_pio_bus.sv
// Randomized bench for ide_pio_bus: each bus cycle is checked clock by clock against a timeline model.
// Also covers IDE_DATA_OE_EN when that macro is defined for both files.
module tb_ide_pio_bus;
  import ide_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ata_rd, ata_wr;
  logic [4:0]  ata_addr;
  logic [15:0] ata_in, ata_out;
  logic        ata_done;
  logic [15:0] ide_data_in, ide_data_out;
  logic        ide_dior, ide_diow;
  logic [1:0]  ide_cs;
  logic [2:0]  ide_da;
`ifdef IDE_DATA_OE_EN
  logic        ide_data_oe;
`endif

  ide_pio_bus dut (
    .clk         (clk),
    .reset       (rst_n),
    .ata_rd      (ata_rd),
    .ata_wr      (ata_wr),
    .ata_addr    (ata_addr),
    .ata_in      (ata_in),
    .ata_out     (ata_out),
    .ata_done    (ata_done),
    .ide_data_in (ide_data_in),
    .ide_data_out(ide_data_out),
    .ide_dior    (ide_dior),
    .ide_diow    (ide_diow),
    .ide_cs      (ide_cs),
    .ide_da      (ide_da)
`ifdef IDE_DATA_OE_EN
    ,
    .ide_data_oe (ide_data_oe)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [15:0] exp_ata_out;
  logic [4:0] reg_tab [9] = '{REG_DATA, REG_ERROR, REG_SECCNT, REG_SECNUM, REG_CYLLOW,
                              REG_CYLHIGH, REG_DRVHEAD, REG_STATUS, REG_ALTER};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      ide_data_in = 16'($urandom);
      @(negedge clk);
      check("idle_cs",   32'(ide_cs),   32'(2'b11));
      check("idle_dior", 32'(ide_dior), 32'd1);
      check("idle_diow", 32'(ide_diow), 32'd1);
      check("idle_done", 32'(ata_done), 32'd0);
      check("idle_out",  32'(ata_out),  32'(exp_ata_out));
    end
  endtask

  // Timeline of one bus cycle, k = clocks after the IDLE clock that saw the request:
  // 1..4 setup, 5..19 strobe, 20..21 hold, 22 done.  Read data is the value on the
  // cable during clock 19 and becomes visible from clock 20 on.
  task automatic do_cycle(input bit rd, input bit wr, input logic [4:0] addr,
                          input logic [15:0] wdat, input logic [15:0] rdat,
                          input bit keep, input int abort_k);
    bit act, strb;
    @(posedge clk); #1;
    ata_rd = rd;
    ata_wr = wr;
    ata_addr = addr;
    ata_in = wdat;
    ide_data_in = 16'($urandom);
    @(negedge clk);
    check("req_cs",   32'(ide_cs),   32'(2'b11));
    check("req_done", 32'(ata_done), 32'd0);
    for (int k = 1; k <= 22; k++) begin
      @(posedge clk); #1;
      if (!keep) begin
        ata_rd = 1'b0;
        ata_wr = 1'b0;
        ata_addr = 5'($urandom);
        ata_in = 16'($urandom);
      end
      ide_data_in = (k == 19) ? rdat : 16'($urandom);
      @(negedge clk);
      act  = (k >= 1) && (k <= 21);
      strb = (k >= 5) && (k <= 19);
      if (rd && k == 20) exp_ata_out = rdat;
      check("cs",   32'(ide_cs),   act ? 32'(addr[4:3]) : 32'(2'b11));
      check("da",   32'(ide_da),   act ? 32'(addr[2:0]) : 32'd0);
      check("dior", 32'(ide_dior), 32'(!(strb && rd)));
      check("diow", 32'(ide_diow), 32'(!(strb && !rd)));
      check("done", 32'(ata_done), 32'(k == 22));
      check("ata_out", 32'(ata_out), 32'(exp_ata_out));
      if (!rd && act) check("data_out", 32'(ide_data_out), 32'(wdat));
`ifdef IDE_DATA_OE_EN
      check("oe", 32'(ide_data_oe), 32'(act && !rd));
`endif
      if (k == abort_k) begin
        #2 rst_n = 1'b0;
        #1;
        exp_ata_out = 16'h0000;
        check("rst_dior", 32'(ide_dior), 32'd1);
        check("rst_diow", 32'(ide_diow), 32'd1);
        check("rst_cs",   32'(ide_cs),   32'(2'b11));
        check("rst_done", 32'(ata_done), 32'd0);
        check("rst_out",  32'(ata_out),  32'd0);
        return;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ata_rd = 1'b0;
    ata_wr = 1'b0;
    ata_addr = 5'd0;
    ata_in = 16'h0;
    ide_data_in = 16'h0;
    exp_ata_out = 16'h0000;
    repeat (2) @(negedge clk);
    check("reset_dior", 32'(ide_dior),     32'd1);
    check("reset_diow", 32'(ide_diow),     32'd1);
    check("reset_cs",   32'(ide_cs),       32'(2'b11));
    check("reset_da",   32'(ide_da),       32'd0);
    check("reset_dout", 32'(ide_data_out), 32'd0);
    check("reset_out",  32'(ata_out),      32'd0);
    check("reset_done", 32'(ata_done),     32'd0);
`ifdef IDE_DATA_OE_EN
    check("reset_oe",   32'(ide_data_oe),  32'd0);
`endif
    @(posedge clk); #1 rst_n = 1'b1;
    idle_cycles(2);

    do_cycle(1'b0, 1'b1, REG_SECCNT, 16'h0001, 16'h0000, 1'b0, 0);
    idle_cycles(1);
    do_cycle(1'b1, 1'b0, REG_STATUS, 16'h0000, 16'h0050, 1'b0, 0);
    @(posedge clk); #1 ide_data_in = 16'h0080;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check("status_held", 32'(ata_out), 32'h0050);
    do_cycle(1'b1, 1'b0, REG_ALTER, 16'h0000, 16'h1234, 1'b0, 0);
    idle_cycles(2);

    // Held read request: back-to-back cycles, fresh data each time
    do_cycle(1'b1, 1'b0, REG_STATUS, 16'h0000, 16'h00d0, 1'b1, 0);
    do_cycle(1'b1, 1'b0, REG_STATUS, 16'h0000, 16'h0050, 1'b1, 0);
    do_cycle(1'b1, 1'b0, REG_STATUS, 16'h0000, 16'h0058, 1'b1, 0);
    ata_rd = 1'b0;
    idle_cycles(2);

    do_cycle(1'b1, 1'b1, REG_DATA, 16'hbeef, 16'h5a5a, 1'b0, 0);
    idle_cycles(1);

    do_cycle(1'b1, 1'b0, REG_STATUS, 16'h0000, 16'h7777, 1'b0, 10);
    repeat (2) begin
      @(negedge clk);
      check("inrst_done", 32'(ata_done), 32'd0);
      check("inrst_cs",   32'(ide_cs),   32'(2'b11));
    end
    @(posedge clk); #1 rst_n = 1'b1;
    idle_cycles(1);
    do_cycle(1'b1, 1'b0, REG_ERROR, 16'h0000, 16'h00a1, 1'b0, 0);
    idle_cycles(1);

    for (int t = 0; t < 20; t++) begin
      int r;
      r = $urandom_range(0, 2);
      do_cycle(r != 1, r != 0, reg_tab[$urandom_range(0, 8)],
               16'($urandom), 16'($urandom), 1'b0, 0);
      idle_cycles($urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
